// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmitter.
package uart_tx_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 115_200;

  // Counter width for a range 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Byte FIFO between the store strobe and the serialiser.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign wr_en    = push & (~full | pop);
  assign rd_en    = pop & ~empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; wrap-around is natural overflow of the extra bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed by CPU byte stores: FIFO plus an 8N1 serialiser, LSB first.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    uart_data,
  input  logic                          uart_write_enablen,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int BW  = cnt_w(CPB);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  uart_state_e   state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          push, pop, empty, baud_done;
  logic [7:0]    head;

  assign push      = ~uart_write_enablen;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign tx_busy   = (state != ST_IDLE) | ~empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (uart_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Next-state logic: pops happen only when a new frame starts (from IDLE or at STOP end).
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
          baud_n  = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift[0];
          state_n = ST_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            bit_n   = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (!empty) begin
            // Back-to-back frame: no idle bit between stop and next start.
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM, counters, shifter and registered line output; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  // Sticky drop flag: a push against a full FIFO with no pop to make room.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            overflow <= 1'b0;
    else if (push && fifo_full && !pop)   overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus random pushes, checked against a
// frame-position model of the line (10 bit slots of CPB clocks each).
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FL    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       wen = 1'b1;
  logic [7:0] data = 8'h00;
  logic       tx, tx_busy, fifo_full, overflow;
  logic [2:0] fifo_count;

  uart_tx #(.CLK_FREQ(16), .BAUD_RATE(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .uart_data          (data),
    .uart_write_enablen (wen),
    .tx                 (tx),
    .tx_busy            (tx_busy),
    .fifo_full          (fifo_full),
    .fifo_count         (fifo_count),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: queued bytes, position within current frame (-1 idle).
  logic [7:0] q[$];
  int         fpos = -1;
  logic [7:0] cur = 8'h00;
  bit         m_ovf = 1'b0;
  int         cyc = 0;
  int         first_low = -1;
  int         peak = 0;
  logic       samp [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level from the slot the frame is in.
  function automatic logic exp_tx();
    int slot;
    if (fpos < 0) return 1'b1;
    slot = fpos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur[slot-1];
  endfunction

  task automatic model_edge(input bit push, input logic [7:0] d);
    bit do_pop;
    do_pop = (fpos < 0 || fpos == FL - 1) && (q.size() > 0);
    if (do_pop) begin
      cur  = q.pop_front();
      fpos = 0;
    end else if (fpos == FL - 1) begin
      fpos = -1;
    end else if (fpos >= 0) begin
      fpos++;
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("tx",    32'(tx),         32'(exp_tx()));
    chk("busy",  32'(tx_busy),    32'(fpos >= 0 || q.size() > 0));
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("full",  32'(fifo_full),  32'(q.size() == DEPTH));
    chk("ovf",   32'(overflow),   32'(m_ovf));
  endtask

  // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
  task automatic step(input bit push, input logic [7:0] d);
    wen  = ~push;
    data = d;
    @(posedge clk);
    cyc++;
    model_edge(push, d);
    #1;
    check_all();
    if (32'(fifo_count) > peak) peak = 32'(fifo_count);
    if (first_low < 0 && tx === 1'b0) first_low = cyc;
    if (first_low >= 0 && cyc - first_low < 64) samp[cyc - first_low] = tx;
    wen = 1'b1;
  endtask

  // Run idle until the line goes quiet; len is cycles from first start bit.
  task automatic measure(input int budget, output int len);
    len = -1;
    for (int i = 0; i < budget; i++) begin
      step(1'b0, 8'h00);
      if (tx_busy === 1'b0) begin
        len = cyc - first_low;
        break;
      end
    end
    total++;
    assert (len >= 0) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=idle within %0d", len, budget);
    end
  endtask

  // Mid-cycle asynchronous reset, checked before any clock edge.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_tx",    32'(tx),         32'd1);
    chk("rst_busy",  32'(tx_busy),    32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_full",  32'(fifo_full),  32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    q.delete();
    fpos  = -1;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Compare captured frame mid-slot against start/data/stop of byte b.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic exp;
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      chk(tag, 32'(samp[k*CPB + CPB/2]), 32'(exp));
    end
  endtask

  int len;

  initial begin
    // 1: reset state and idle line
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_tx",    32'(tx),         32'd1);
    chk("init_busy",  32'(tx_busy),    32'd0);
    chk("init_count", 32'(fifo_count), 32'd0);
    chk("init_ovf",   32'(overflow),   32'd0);
    rstn = 1'b1;
    repeat (6) step(1'b0, 8'h00);

    // 2: single byte 0xA5
    first_low = -1;
    step(1'b1, 8'hA5);
    measure(60, len);
    chk("a5_len", 32'(len), 32'd40);
    check_frame("a5_bit", 8'hA5);

    // 3: three-byte burst, frames back-to-back
    first_low = -1;
    peak = 0;
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    measure(160, len);
    chk("burst_len",  32'(len),  32'd120);
    chk("burst_peak", 32'(peak), 32'd2);

    // 4: six pushes while idle, sixth dropped
    first_low = -1;
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_flag", 32'(overflow),  32'd1);
    measure(260, len);
    chk("ovf_len",   32'(len),      32'd200);
    chk("ovf_stick", 32'(overflow), 32'd1);

    // 5: push on the same edge the full FIFO pops at stop end
    do_reset();
    first_low = -1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    for (int i = 0; i < 60 && fpos != FL - 1; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    chk("same_edge_count", 32'(fifo_count), 32'd4);
    chk("same_edge_ovf",   32'(overflow),   32'd0);
    measure(300, len);
    chk("same_edge_len", 32'(len), 32'd240);

    // random pushes against the model
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) == 0, 8'($urandom));
    measure(300, len);

    // 6: reset in the middle of DATA, then a clean frame
    do_reset();
    step(1'b1, 8'hFF);
    step(1'b1, 8'h11);
    repeat (15) step(1'b0, 8'h00);
    do_reset();
    first_low = -1;
    step(1'b1, 8'h3C);
    measure(60, len);
    chk("post_rst_len", 32'(len), 32'd40);
    check_frame("post_rst_bit", 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
